reg_preload: RTL and testbench

Register-file preload engine for the processor wrapper. It sits between the processor's register-file write port and the regfile. When started, it holds the processor and writes a stream of 32-bit words into r1..r31 in order through the regfile write port. It is the writer-side counterpart of the harness register dump, which reads r0..r31 by hijacking read port A. When idle, it passes the processor's write port through unchanged.

---
 rtl/reg_preload_pkg.sv | 15 +
 rtl/reg_preload.sv | 128 ++++++++++++
 tb/tb_reg_preload.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_preload_pkg.sv
// Shared widths and FSM encoding for the register-file preload engine.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package reg_preload_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/reg_preload.sv
// Preloads r1..r31 from a word stream through the regfile write port, holding the CPU.
// Latency: an accepted word reaches the regfile write port one cycle later; done pulses one cycle after the final write.
// Backpressure: in_ready is high for every LOAD cycle and depends on state only; the source may stall with in_valid.
module reg_preload
    import reg_preload_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int FIRST_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              cpu_rwe,
    input  logic [REG_W-1:0]  cpu_rd,
    input  logic [DATA_W-1:0] cpu_rData,
    output logic              rwe,
    output logic [REG_W-1:0]  rd,
    output logic [DATA_W-1:0] rData,
    output logic              cpu_hold,
    output logic              done,
    output logic [REG_W-1:0]  loaded
);

    localparam logic [REG_W-1:0] FIRST_IDX = REG_W'(FIRST_REG);
    localparam logic [REG_W-1:0] LAST_IDX  = REG_W'(NUM_REGS - 1);
    localparam logic [REG_W-1:0] ONE       = REG_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [REG_W-1:0]    r_idx;
    logic [REG_W-1:0]    r_loaded;
    logic                r_done;
    logic                r_wen;
    logic [REG_W-1:0]    r_wrd;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_start;
    logic                w_accept;
    logic                w_in_ready;

    // State register; reset drops any in-flight write by returning straight to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; LOAD ends on in_last or on the last register index.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                w_accept   = in_valid;
                if (in_valid && (in_last || (r_idx == LAST_IDX))) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write-register stage, target index, word count and the done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx    <= FIRST_IDX;
            r_loaded <= '0;
            r_done   <= 1'b0;
            r_wen    <= 1'b0;
            r_wrd    <= '0;
            r_wdata  <= '0;
        end else begin
            r_done <= (r_state == ST_FLUSH);
            r_wen  <= w_accept;
            if (w_start) begin
                r_idx    <= FIRST_IDX;
                r_loaded <= '0;
            end
            if (w_accept) begin
                r_wrd    <= r_idx;
                r_wdata  <= in_data;
                r_loaded <= r_loaded + ONE;
                // Hold at the last index instead of wrapping; LOAD exits here anyway.
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + ONE;
                end
            end
        end
    end

    // Output mux: the processor owns the write port only while idle.
    always_comb begin
        if (r_state == ST_IDLE) begin
            rwe   = cpu_rwe;
            rd    = cpu_rd;
            rData = cpu_rData;
        end else begin
            rwe   = r_wen;
            rd    = r_wrd;
            rData = r_wdata;
        end
    end

    assign in_ready = w_in_ready;
    assign cpu_hold = (r_state != ST_IDLE);
    assign done     = r_done;
    assign loaded   = r_loaded;

endmodule

// File: tb/tb_reg_preload.sv
// Randomized bench for reg_preload with an emulated regfile and an array-based expected model.
// Latency: n/a (testbench).
// Backpressure: source stalls are injected randomly or from a fixed valid pattern.
module tb_reg_preload;

    localparam int NREG  = 32;
    localparam int FIRST = 1;

    logic        clock;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        cpu_rwe;
    logic [4:0]  cpu_rd;
    logic [31:0] cpu_rData;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] rData;
    logic        cpu_hold;
    logic        done;
    logic [4:0]  loaded;

    reg_preload #(.NUM_REGS(NREG), .FIRST_REG(FIRST)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .cpu_rwe   (cpu_rwe),
        .cpu_rd    (cpu_rd),
        .cpu_rData (cpu_rData),
        .rwe       (rwe),
        .rd        (rd),
        .rData     (rData),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .loaded    (loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Emulated regfile plus write/done monitors.
    logic [31:0] rf [NREG];
    logic [31:0] exp_rf [NREG];
    logic [31:0] words [NREG];
    logic [4:0]  wr_q [$];
    int          n_done;
    logic        rf_init;
    int          n_chk;
    int          n_pass;

    function automatic logic [31:0] init_val(input int r);
        return (r == 0) ? 32'd0 : (32'hA500_0000 + 32'(r));
    endfunction

    always @(posedge clock) begin
        if (rf_init) begin
            for (int r = 0; r < NREG; r++) rf[r] <= init_val(r);
        end else if (rwe) begin
            rf[rd] <= rData;
        end
    end

    initial n_done = 0;
    always @(posedge clock) begin
        if (rwe) wr_q.push_back(rd);
        if (done) n_done = n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    endtask

    function automatic int rf_bad();
        int bad = 0;
        for (int r = 0; r < NREG; r++) if (rf[r] !== exp_rf[r]) bad++;
        return bad;
    endfunction

    // One preload of n words from words[]; junk adds start+in_valid in IDLE and start mid-LOAD.
    task automatic run_load(input int n, input int stall_pct, input bit use_pat,
                            input logic [3:0] vpat, input bit junk, input bit use_last);
        int  i, cyc, bad, wbase, dbase;
        bit  v;
        i = 0; cyc = 0; bad = 0;
        wbase = wr_q.size();
        dbase = n_done;
        @(negedge clock);
        start = 1'b1;
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 32'hBAD0_0000 | $urandom_range(255);
            in_last  = 1'b1;
        end
        @(negedge clock);
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("hold_in_load", 32'(cpu_hold), 32'd1);
        chk("ready_in_load", 32'(in_ready), 32'd1);
        while (i < n && cyc < 400) begin
            if (use_pat && cyc < 4) v = vpat[cyc];
            else v = ($urandom_range(99) >= stall_pct);
            in_valid = v;
            in_data  = v ? words[i] : $urandom;
            in_last  = (i == n - 1) && (use_last || n < NREG - FIRST);
            start    = junk && (cyc == 2);
            @(negedge clock);
            if (v) i++;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        if (i < n) chk("load_timeout", 32'(i), 32'(n));
        // FLUSH cycle: final write on the port, CPU still held.
        chk("flush_hold", 32'(cpu_hold), 32'd1);
        chk("flush_ready", 32'(in_ready), 32'd0);
        chk("flush_rwe", 32'(rwe), 32'd1);
        chk("flush_rd", 32'(rd), 32'(FIRST + n - 1));
        chk("flush_data", rData, words[n-1]);
        chk("flush_nodone", 32'(done), 32'd0);
        @(negedge clock);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_hold_low", 32'(cpu_hold), 32'd0);
        chk("loaded", 32'(loaded), 32'(n));
        @(negedge clock);
        chk("done_single", 32'(done), 32'd0);
        chk("loaded_held", 32'(loaded), 32'(n));
        for (int k = 0; k < n; k++) exp_rf[FIRST + k] = words[k];
        chk("rf_contents", 32'(rf_bad()), 32'd0);
        chk("write_count", 32'(wr_q.size() - wbase), 32'(n));
        for (int j = 0; j < n && wbase + j < wr_q.size(); j++)
            if (wr_q[wbase + j] != 5'(FIRST + j)) bad++;
        chk("write_order", 32'(bad), 32'd0);
        chk("done_count", 32'(n_done - dbase), 32'd1);
    endtask

    initial begin
        int n, dbase;
        n_chk = 0; n_pass = 0;
        reset = 1'b1; rf_init = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        cpu_rwe = 1'b0; cpu_rd = '0; cpu_rData = '0;
        for (int r = 0; r < NREG; r++) exp_rf[r] = init_val(r);
        repeat (2) @(negedge clock);
        rf_init = 1'b0;
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_rwe", 32'(rwe), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Pass-through while idle; a stray in_valid must not be acknowledged.
        cpu_rwe = 1'b1; cpu_rd = 5'd9; cpu_rData = 32'd42; in_valid = 1'b1;
        #1;
        chk("pt_rwe", 32'(rwe), 32'd1);
        chk("pt_rd", 32'(rd), 32'd9);
        chk("pt_data", rData, 32'd42);
        chk("pt_ready", 32'(in_ready), 32'd0);
        chk("pt_hold", 32'(cpu_hold), 32'd0);
        @(negedge clock);
        cpu_rwe = 1'b0; in_valid = 1'b0;
        exp_rf[9] = 32'd42;
        @(negedge clock);
        chk("pt_rf9", rf[9], 32'd42);

        // Full load 1..31, no gaps, exit on the last index without in_last.
        for (int k = 0; k < 31; k++) words[k] = 32'(k + 1);
        run_load(31, 0, 1'b0, 4'b0, 1'b0, 1'b0);
        chk("full_r0", rf[0], 32'd0);

        // Short load with in_last on the third word.
        words[0] = 32'hDEADBEEF; words[1] = 32'd5; words[2] = -32'sd7;
        run_load(3, 0, 1'b0, 4'b0, 1'b0, 1'b1);

        // Stalled source: valid pattern 1,0,0,1.
        words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
        run_load(2, 0, 1'b1, 4'b1001, 1'b0, 1'b1);

        // Single word with in_last, plus ignored start/in_valid junk.
        words[0] = $urandom;
        run_load(1, 0, 1'b0, 4'b0, 1'b1, 1'b1);

        // Randomized loads.
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(31, 1);
            for (int k = 0; k < n; k++) words[k] = $urandom;
            run_load(n, $urandom_range(60), 1'b0, 4'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Reset after 10 accepts: the r10 write is still in flight and must be dropped.
        for (int k = 0; k < 10; k++) words[k] = $urandom;
        dbase = n_done;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = words[k]; in_last = 1'b0;
            @(negedge clock);
        end
        chk("rst_inflight_rd", 32'(rd), 32'd10);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_mid_hold", 32'(cpu_hold), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        chk("rst_mid_rwe", 32'(rwe), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 9; k++) exp_rf[FIRST + k] = words[k];
        chk("rst_mid_rf", 32'(rf_bad()), 32'd0);
        chk("rst_mid_nodone", 32'(n_done - dbase), 32'd0);

        // Recovery after reset.
        for (int k = 0; k < 31; k++) words[k] = $urandom;
        run_load(31, 20, 1'b0, 4'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
